mem_arbiter: RTL and testbench

Shares the single memory_interface port between the CPU datapath and a debug/loader requester (UART program loader, host peek/poke). It grants one single-cycle access per clock using round-robin on contention. It supports a debug lock for atomic bursts and bounds CPU starvation with a wait counter. It sits between the mem_addr_src mux / rd2_buf and memory_interface, and drives cpu_stall to the control unit.

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/debug requesters, the arbiter and memory_interface.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wd;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_rd;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wd;
    logic              dbg_lock;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rd;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd,
        output cpu_gnt, cpu_rd, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wd, dbg_lock,
        output dbg_gnt, dbg_rd,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd,
        input  cpu_gnt, cpu_rd, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wd, dbg_lock,
        input  dbg_gnt, dbg_rd,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the CPU datapath and a debug/loader requester:
// round-robin on contention, debug lock for atomic bursts, bounded CPU starvation.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rstn,
    mem_arbiter_if.slave  bus
);
    typedef enum logic { IDLE, LOCKED } fsm_t;
    typedef enum logic { OWN_CPU, OWN_DBG } owner_t;

    fsm_t              fsm_reg, fsm_next;
    owner_t            last_owner_reg, last_owner_next;
    logic [7:0]        wait_cnt_reg, wait_cnt_next;

    logic              gnt_cpu, gnt_dbg, forced;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wd;

    assign forced = (wait_cnt_reg == 8'(MAX_WAIT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_reg        <= IDLE;
            last_owner_reg <= OWN_DBG;
            wait_cnt_reg   <= 8'd0;
        end else begin
            fsm_reg        <= fsm_next;
            last_owner_reg <= last_owner_next;
            wait_cnt_reg   <= wait_cnt_next;
        end
    end

    // Grants are suppressed while reset is held so a pending write never reaches memory.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dbg = 1'b0;
        if (rstn) begin
            case (fsm_reg)
                IDLE: begin
                    if (bus.cpu_req && bus.dbg_req) begin
                        if (last_owner_reg == OWN_DBG) gnt_cpu = 1'b1;
                        else                           gnt_dbg = 1'b1;
                    end else begin
                        gnt_cpu = bus.cpu_req;
                        gnt_dbg = bus.dbg_req;
                    end
                end
                LOCKED: begin
                    if (bus.dbg_req && !(bus.cpu_req && forced)) gnt_dbg = 1'b1;
                    else                                          gnt_cpu = bus.cpu_req;
                end
                default: begin
                    gnt_cpu = 1'b0;
                    gnt_dbg = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        fsm_next        = fsm_reg;
        last_owner_next = last_owner_reg;
        wait_cnt_next   = wait_cnt_reg;

        case (fsm_reg)
            IDLE:    if (gnt_dbg && bus.dbg_lock) fsm_next = LOCKED;
            LOCKED:  if (!bus.dbg_lock)           fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase

        if (gnt_cpu)      last_owner_next = OWN_CPU;
        else if (gnt_dbg) last_owner_next = OWN_DBG;

        // Counter saturates at MAX_WAIT so the forced grant fires exactly once per starvation run.
        if (!bus.cpu_req || gnt_cpu) wait_cnt_next = 8'd0;
        else if (!forced)            wait_cnt_next = wait_cnt_reg + 8'd1;
    end

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = bus.cpu_addr;
        sel_wd   = bus.cpu_wd;
        if (gnt_dbg) begin
            sel_we   = bus.dbg_we;
            sel_addr = bus.dbg_addr;
            sel_wd   = bus.dbg_wd;
        end else if (gnt_cpu) begin
            sel_we   = bus.cpu_we;
        end
    end

    assign bus.mem_we    = sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wd    = sel_wd;
    assign bus.cpu_gnt   = gnt_cpu;
    assign bus.dbg_gnt   = gnt_dbg;
    assign bus.cpu_stall = bus.cpu_req & ~gnt_cpu;
    assign bus.cpu_rd    = bus.mem_rd;
    assign bus.dbg_rd    = bus.mem_rd;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small word-addressed memory model.
module tb_mem_arbiter;
    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem_model [0:1023];
    assign bus.mem_rd = mem_model[bus.mem_addr[11:2]];
    always @(posedge clk) begin
        if (bus.mem_we) mem_model[bus.mem_addr[11:2]] <= bus.mem_wd;
    end

    always @(negedge clk) begin
        if (bus.cpu_gnt)
            $display("txn cpu we=%0d addr=%h wd=%h rd=%h", bus.mem_we, bus.mem_addr, bus.mem_wd, bus.cpu_rd);
        if (bus.dbg_gnt)
            $display("txn dbg we=%0d addr=%h wd=%h rd=%h", bus.mem_we, bus.mem_addr, bus.mem_wd, bus.dbg_rd);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.cpu_req  = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wd = '0;
        bus.dbg_req  = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wd = '0;
        bus.dbg_lock = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
        clear_inputs();
        rstn = 1'b0;

        // Reset held with a request present: nothing is granted, no write.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        @(negedge clk);
        check("rst_cpu_gnt", bus.cpu_gnt, 1'b0);
        check("rst_dbg_gnt", bus.dbg_gnt, 1'b0);
        check("rst_mem_we",  bus.mem_we,  1'b0);
        @(posedge clk); #1;
        do_reset();

        // Idle after release.
        @(negedge clk);
        check("idle_cpu_gnt", bus.cpu_gnt, 1'b0);
        check("idle_dbg_gnt", bus.dbg_gnt, 1'b0);
        check("idle_mem_we",  bus.mem_we,  1'b0);
        next_cycle();

        // Uncontended CPU write: granted in the same cycle.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h100; bus.cpu_wd = 32'hDEADBEEF;
        @(negedge clk);
        check("cpuw_gnt",   bus.cpu_gnt,   1'b1);
        check("cpuw_we",    bus.mem_we,    1'b1);
        check("cpuw_addr",  bus.mem_addr,  32'h100);
        check("cpuw_wd",    bus.mem_wd,    32'hDEADBEEF);
        check("cpuw_stall", bus.cpu_stall, 1'b0);
        next_cycle();
        bus.cpu_we = 1'b0;
        @(negedge clk);
        check("cpuw_readback", bus.cpu_rd, 32'hDEADBEEF);
        next_cycle();

        // Continuous contention, no lock: CPU, DBG, CPU, DBG ...
        do_reset();
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h200;
        bus.dbg_req = 1'b1; bus.dbg_addr = 32'h300;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rr_cpu_gnt_%0d", c), bus.cpu_gnt,   (c % 2) == 0);
            check($sformatf("rr_dbg_gnt_%0d", c), bus.dbg_gnt,   (c % 2) == 1);
            check($sformatf("rr_stall_%0d", c),   bus.cpu_stall, (c % 2) == 1);
            check($sformatf("rr_addr_%0d", c),    bus.mem_addr,  ((c % 2) == 0) ? 32'h200 : 32'h300);
            next_cycle();
        end

        // Locked debug burst against a waiting CPU: 8 DBG then 1 forced CPU grant.
        do_reset();
        bus.cpu_req = 1'b1; bus.dbg_req = 1'b1; bus.dbg_lock = 1'b1;
        for (int c = 0; c < 20; c++) begin
            logic exp_cpu;
            exp_cpu = (c == 0) || (((c - 1) % 9) == 8);
            @(negedge clk);
            check($sformatf("lock_cpu_gnt_%0d", c), bus.cpu_gnt, exp_cpu);
            check($sformatf("lock_dbg_gnt_%0d", c), bus.dbg_gnt, !exp_cpu);
            next_cycle();
        end
        // Lock released: one more locked DBG cycle, then round-robin from CPU.
        bus.dbg_lock = 1'b0;
        @(negedge clk);
        check("unlock_dbg_gnt_0", bus.dbg_gnt, 1'b1);
        next_cycle();
        @(negedge clk);
        check("unlock_cpu_gnt_1", bus.cpu_gnt, 1'b1);
        next_cycle();
        @(negedge clk);
        check("unlock_dbg_gnt_2", bus.dbg_gnt, 1'b1);
        next_cycle();

        // dbg_lock without a debug grant must not lock the bus.
        do_reset();
        bus.cpu_req = 1'b1; bus.dbg_lock = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("nolock_cpu_gnt_%0d", c), bus.cpu_gnt, 1'b1);
            next_cycle();
        end
        bus.dbg_lock = 1'b0; bus.dbg_req = 1'b1;
        @(negedge clk);
        check("nolock_dbg_turn", bus.dbg_gnt, 1'b1);
        next_cycle();
        @(negedge clk);
        check("nolock_cpu_turn", bus.cpu_gnt, 1'b1);
        next_cycle();

        // Debug write then CPU read of the same word.
        do_reset();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h40; bus.dbg_wd = 32'h12345678;
        @(negedge clk);
        check("dbgw_gnt",  bus.dbg_gnt,  1'b1);
        check("dbgw_we",   bus.mem_we,   1'b1);
        check("dbgw_addr", bus.mem_addr, 32'h40);
        next_cycle();
        clear_inputs();
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h40;
        @(negedge clk);
        check("cpur_gnt", bus.cpu_gnt, 1'b1);
        check("cpur_we",  bus.mem_we,  1'b0);
        check("cpur_rd",  bus.cpu_rd,  32'h12345678);
        next_cycle();

        // Reset pulsed mid-lock during a debug write: the write is dropped.
        do_reset();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_lock = 1'b1;
        bus.dbg_addr = 32'h80; bus.dbg_wd = 32'hAAAA5555;
        @(negedge clk);
        check("rstw_first_gnt", bus.dbg_gnt, 1'b1);
        next_cycle();
        bus.dbg_wd = 32'hBBBB0000;
        @(negedge clk);
        check("rstw_locked_gnt", bus.dbg_gnt, 1'b1);
        #1 rstn = 1'b0;
        #1;
        check("rstw_gnt_in_rst", bus.dbg_gnt, 1'b0);
        check("rstw_we_in_rst",  bus.mem_we,  1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0;
        @(negedge clk);
        check("rstw_idle_cpu_gnt", bus.cpu_gnt, 1'b0);
        check("rstw_idle_dbg_gnt", bus.dbg_gnt, 1'b0);
        next_cycle();
        // dbg_lock still high: a CPU win here proves the FSM left LOCKED.
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h80; bus.dbg_req = 1'b1;
        @(negedge clk);
        check("rstw_tie_cpu_gnt", bus.cpu_gnt, 1'b1);
        check("rstw_tie_dbg_gnt", bus.dbg_gnt, 1'b0);
        check("rstw_kept_data",   bus.cpu_rd,  32'hAAAA5555);
        next_cycle();
        clear_inputs();
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
